// File: rtl/btn_pkg.sv
// Shared constants and counter-sizing helpers for the multi-channel button debouncer.
package btn_pkg;

    localparam int DEF_DIV_40HZ     = 1250000;
    localparam int DEF_STABLE       = 2;
    localparam int DEF_REPEAT_DELAY = 20;
    localparam int DEF_REPEAT_RATE  = 4;

    // Bits needed to hold 0..value-1, never fewer than one.
    function automatic int clog2_safe(input int value);
        int bits;
        bits = 1;
        while ((1 << bits) < value) begin
            bits++;
        end
        return bits;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_chan.sv
// One debounce channel: 2-FF synchroniser, tick-sampled stability counter, level and pulses.
// Auto-repeat counter is generated only when BTN_REPEAT_EN is defined.
module btn_chan
    import btn_pkg::*;
#(
    parameter int STABLE       = DEF_STABLE,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic pin_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    if (STABLE < 1 || STABLE > 15 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
        $error("btn_chan: STABLE must be 1..15, REPEAT_DELAY and REPEAT_RATE >= 1");
    end

    localparam int              STB_W    = clog2_safe(STABLE);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE - 1);

    logic [1:0]       sync_q;
    logic             sample;
    logic [STB_W-1:0] stab_q, stab_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    assign sample = sync_q[1] ^ ACTIVE_LOW;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        stab_d    = stab_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (tick_i) begin
            if (sample == level_q) begin
                stab_d = '0;
            end else if (stab_q == STB_LAST) begin
                stab_d    = '0;
                level_d   = ~level_q;
                press_d   = ~level_q;
                release_d = level_q;
            end else begin
                stab_d = stab_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q    <= {2{ACTIVE_LOW}};
            stab_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], pin_i};
            stab_q    <= stab_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

`ifdef BTN_REPEAT_EN
    localparam int RPT_W = clog2_safe(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);
    localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
    // Modular reload: RATE > DELAY still lands on RPT_LAST after exactly RATE ticks.
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_RATE);

    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             repeat_q, repeat_d;

    always_comb begin
        rpt_d    = rpt_q;
        repeat_d = 1'b0;
        if (!level_q || release_d) begin
            rpt_d = '0;
        end else if (tick_i) begin
            if (rpt_q == RPT_LAST) begin
                rpt_d    = RPT_RELOAD;
                repeat_d = 1'b1;
            end else begin
                rpt_d = rpt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rpt_q    <= '0;
            repeat_q <= 1'b0;
        end else begin
            rpt_q    <= rpt_d;
            repeat_q <= repeat_d;
        end
    end

    assign repeat_o = repeat_q;
`else
    assign repeat_o = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce_multi.sv
// N-channel push-button debouncer: one shared sample-tick prescaler feeding N_BTN btn_chan instances.
// Define BTN_REPEAT_EN to build the auto-repeat counters; otherwise REPEAT is held at 0.
module btn_debounce_multi
    import btn_pkg::*;
#(
    parameter int N_BTN        = 3,
    parameter int DIV          = DEF_DIV_40HZ,
    parameter int STABLE       = DEF_STABLE,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_BTN-1:0] BIN,
    output logic [N_BTN-1:0] LEVEL,
    output logic [N_BTN-1:0] PRESS,
    output logic [N_BTN-1:0] RELEASE,
    output logic [N_BTN-1:0] REPEAT,
    output logic             TICK
);

    if (DIV < 2) begin : g_bad_div
        $error("btn_debounce_multi: DIV must be >= 2");
    end

    localparam int               PRE_W    = clog2_safe(DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick;
    logic             tick_q;

    assign tick  = (pre_q == PRE_LAST);
    assign pre_d = tick ? '0 : pre_q + 1'b1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick;
        end
    end

    assign TICK = tick_q;

    // Channels see the unregistered tick so their outputs change together with TICK.
    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        btn_chan #(
            .STABLE       (STABLE),
            .ACTIVE_LOW   (ACTIVE_LOW),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_chan (
            .clk_i     (CLK),
            .rst_i     (RST),
            .tick_i    (tick),
            .pin_i     (BIN[g]),
            .level_o   (LEVEL[g]),
            .press_o   (PRESS[g]),
            .release_o (RELEASE[g]),
            .repeat_o  (REPEAT[g])
        );
    end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Self-checking bench for btn_debounce_multi: directed scenarios plus random pin activity,
// each cycle compared against a tick-level reference model of the debounce rules.
module tb_btn_debounce_multi;

    localparam int N_BTN  = 3;
    localparam int DIV    = 4;
    localparam int STABLE = 3;
    localparam int DELAY  = 5;
    localparam int RATE   = 2;
    localparam bit ACTIVE_LOW = 1'b1;
    localparam logic [N_BTN-1:0] RELEASED = {N_BTN{ACTIVE_LOW}};
`ifdef BTN_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N_BTN-1:0] bin = RELEASED;
    logic [N_BTN-1:0] level, press, rel, rpt;
    logic             tick;
    logic [4*N_BTN:0] obs_v;
    logic [4*N_BTN:0] exp_v = '0;

    int n_checks = 0;
    int n_pass   = 0;

    btn_debounce_multi #(
        .N_BTN        (N_BTN),
        .DIV          (DIV),
        .STABLE       (STABLE),
        .ACTIVE_LOW   (ACTIVE_LOW),
        .REPEAT_DELAY (DELAY),
        .REPEAT_RATE  (RATE)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .BIN     (bin),
        .LEVEL   (level),
        .PRESS   (press),
        .RELEASE (rel),
        .REPEAT  (rpt),
        .TICK    (tick)
    );

    always #5 clk = ~clk;

    assign obs_v = {tick, level, press, rel, rpt};

    // Reference model: pin history since reset, per-channel run length of differing samples,
    // and ticks held since the press.
    logic [N_BTN-1:0] hist[$];
    logic [N_BTN-1:0] m_level = '0;
    int               m_run[N_BTN];
    int               m_held[N_BTN];

    task automatic model_clear();
        hist.delete();
        m_level = '0;
        for (int ch = 0; ch < N_BTN; ch++) begin
            m_run[ch]  = 0;
            m_held[ch] = 0;
        end
    endtask

    task automatic model_edge(input logic [N_BTN-1:0] pins);
        int               k;
        logic             tick_e;
        logic [N_BTN-1:0] pressed, p_e, r_e, rep_e;
        hist.push_back(pins);
        k       = hist.size() - 1;
        tick_e  = (k % DIV) == DIV - 1;
        pressed = (k >= 2) ? (hist[k-2] ^ {N_BTN{ACTIVE_LOW}}) : '0;
        p_e     = '0;
        r_e     = '0;
        rep_e   = '0;
        if (tick_e) begin
            for (int ch = 0; ch < N_BTN; ch++) begin
                if (pressed[ch] != m_level[ch]) begin
                    m_run[ch]++;
                    if (m_run[ch] == STABLE) begin
                        m_level[ch] = pressed[ch];
                        m_run[ch]   = 0;
                        if (pressed[ch]) p_e[ch] = 1'b1;
                        else r_e[ch] = 1'b1;
                    end
                end else begin
                    m_run[ch] = 0;
                end
                if (m_level[ch] && !p_e[ch]) begin
                    m_held[ch]++;
                    if (REPEAT_ON && m_held[ch] >= DELAY && (m_held[ch] - DELAY) % RATE == 0)
                        rep_e[ch] = 1'b1;
                end else begin
                    m_held[ch] = 0;
                end
            end
        end
        exp_v = {tick_e, m_level, p_e, r_e, rep_e};
    endtask

    task automatic step(input logic [N_BTN-1:0] pins, input logic r);
        @(negedge clk);
        bin = pins;
        rst = r;
        @(posedge clk);
        #1;
        if (r) begin
            model_clear();
            exp_v = '0;
        end else begin
            model_edge(pins);
        end
    endtask

    // Idle until the next edge is the first of a prescaler period.
    task automatic align();
        while (hist.size() % DIV != 0) step(bin, 1'b0);
    endtask

    task automatic test_reset();
        int n_tick = 0;
        int first_tick = -1;
        for (int i = 0; i < 40; i++) begin
            step(RELEASED, 1'b1);
            n_checks++;
            if (obs_v !== '0) $display("FAIL reset_hold %0d: got %b, want all zero", i, obs_v);
            else n_pass++;
        end
        for (int i = 0; i < 16; i++) begin
            step(RELEASED, 1'b0);
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL reset_exit %0d: got %b, want %b", i, obs_v, exp_v);
            else n_pass++;
            if (tick) begin
                n_tick++;
                if (first_tick < 0) first_tick = i + 1;
            end
        end
        n_checks++;
        if (n_tick != 4) $display("FAIL tick_count: got %0d, want 4", n_tick);
        else n_pass++;
        n_checks++;
        if (first_tick != DIV) $display("FAIL tick_first: got %0d, want %0d", first_tick, DIV);
        else n_pass++;
    endtask

    task automatic test_press();
        logic [N_BTN-1:0] pins = RELEASED ^ N_BTN'(1);
        int rise_at = -1, press_at = -1, n_press = 0, n_other = 0, n_rel = 0;
        repeat ($urandom_range(0, DIV - 1)) step(RELEASED, 1'b0);
        for (int i = 0; i < 24; i++) begin
            step(pins, 1'b0);
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL press_cycle %0d: got %b, want %b", i, obs_v, exp_v);
            else n_pass++;
            if (level[0] && rise_at < 0) rise_at = i + 1;
            if (press[0]) begin
                n_press++;
                press_at = i + 1;
            end
            if ((level[2:1] | press[2:1]) != 2'b00) n_other++;
        end
        n_checks++;
        if (rise_at < 11 || rise_at > 15) $display("FAIL press_latency: got %0d, want 11..15", rise_at);
        else n_pass++;
        n_checks++;
        if (n_press != 1 || press_at != rise_at)
            $display("FAIL press_pulse: got %0d pulses at %0d, want 1 at %0d", n_press, press_at, rise_at);
        else n_pass++;
        n_checks++;
        if (n_other != 0) $display("FAIL press_quiet: got %0d active cycles, want 0", n_other);
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            step(RELEASED, 1'b0);
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL press_release %0d: got %b, want %b", i, obs_v, exp_v);
            else n_pass++;
            if (rel[0]) n_rel++;
        end
        n_checks++;
        if (n_rel != 1 || level !== '0) $display("FAIL press_rel_count: got %0d level %b, want 1 level 000", n_rel, level);
        else n_pass++;
    endtask

    task automatic test_glitch();
        logic [N_BTN-1:0] low1 = RELEASED ^ N_BTN'(2);
        int n_bad = 0, n_press = 0, press_at = -1, n_rel = 0, ph;
        for (int i = 0; i < 24; i++) begin
            step((i < 2 * DIV) ? low1 : RELEASED, 1'b0);
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL glitch_cycle %0d: got %b, want %b", i, obs_v, exp_v);
            else n_pass++;
            if (level[1] || press[1]) n_bad++;
        end
        n_checks++;
        if (n_bad != 0) $display("FAIL glitch_level: got %0d active cycles, want 0", n_bad);
        else n_pass++;
        align();
        // Per-tick pattern L,H,L,L,L,L,L,L then released.
        for (int i = 0; i < 52; i++) begin
            ph = i / DIV;
            step((ph == 1 || ph >= 8) ? RELEASED : low1, 1'b0);
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL bounce_cycle %0d: got %b, want %b", i, obs_v, exp_v);
            else n_pass++;
            if (press[1]) begin
                n_press++;
                press_at = i + 1;
            end
            if (rel[1]) n_rel++;
        end
        n_checks++;
        if (n_press != 1 || press_at != 20)
            $display("FAIL bounce_press: got %0d pulses at %0d, want 1 at 20", n_press, press_at);
        else n_pass++;
        n_checks++;
        if (n_rel != 1) $display("FAIL bounce_release: got %0d, want 1", n_rel);
        else n_pass++;
    endtask

    task automatic test_repeat();
        logic [N_BTN-1:0] low2 = RELEASED ^ N_BTN'(4);
        int press_at = -1, rel_at = -1, n_rep = 0, first_rep = -1, last_rep = -1, rep_after = 0;
        align();
        for (int i = 0; i < 92; i++) begin
            step((i < 52) ? low2 : RELEASED, 1'b0);
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL repeat_cycle %0d: got %b, want %b", i, obs_v, exp_v);
            else n_pass++;
            if (press[2]) press_at = i + 1;
            if (rel[2]) rel_at = i + 1;
            if (rpt[2]) begin
                n_rep++;
                if (first_rep < 0) first_rep = i + 1;
                last_rep = i + 1;
                if (rel_at > 0 || !level[2]) rep_after++;
            end
        end
        n_checks++;
        if (press_at != 12) $display("FAIL repeat_press: got %0d, want 12", press_at);
        else n_pass++;
        n_checks++;
        if (n_rep != (REPEAT_ON ? 4 : 0)) $display("FAIL repeat_count: got %0d, want %0d", n_rep, REPEAT_ON ? 4 : 0);
        else n_pass++;
        n_checks++;
        if (first_rep != (REPEAT_ON ? 32 : -1) || last_rep != (REPEAT_ON ? 56 : -1))
            $display("FAIL repeat_timing: got %0d..%0d, want %0d..%0d", first_rep, last_rep,
                     REPEAT_ON ? 32 : -1, REPEAT_ON ? 56 : -1);
        else n_pass++;
        n_checks++;
        if (rel_at != 64 || rep_after != 0)
            $display("FAIL repeat_release: got rel at %0d with %0d late repeats, want 64 with 0", rel_at, rep_after);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [N_BTN-1:0] both = RELEASED ^ N_BTN'(5);
        int n_both = 0, n_partial = 0, n_rel_both = 0;
        for (int i = 0; i < 20; i++) begin
            step(both, 1'b0);
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL b2b_cycle %0d: got %b, want %b", i, obs_v, exp_v);
            else n_pass++;
            if (press == 3'b101) n_both++;
            else if (press != 3'b000) n_partial++;
        end
        n_checks++;
        if (n_both != 1 || n_partial != 0)
            $display("FAIL b2b_press: got %0d joint, %0d partial, want 1 joint, 0 partial", n_both, n_partial);
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            step(RELEASED, 1'b0);
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL b2b_release %0d: got %b, want %b", i, obs_v, exp_v);
            else n_pass++;
            if (rel == 3'b101) n_rel_both++;
        end
        n_checks++;
        if (n_rel_both != 1) $display("FAIL b2b_rel_joint: got %0d, want 1", n_rel_both);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        logic [N_BTN-1:0] low0 = RELEASED ^ N_BTN'(1);
        int n_early = 0, press_at = -1, n_press = 0;
        align();
        for (int i = 0; i < 14; i++) begin
            step(low0, (i >= 8) ? 1'b1 : 1'b0);
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL abort_cycle %0d: got %b, want %b", i, obs_v, exp_v);
            else n_pass++;
            if (press != '0 || level != '0) n_early++;
        end
        n_checks++;
        if (n_early != 0) $display("FAIL abort_silent: got %0d active cycles, want 0", n_early);
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            step(low0, 1'b0);
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL abort_resume %0d: got %b, want %b", i, obs_v, exp_v);
            else n_pass++;
            if (press[0]) begin
                n_press++;
                press_at = i + 1;
            end
        end
        n_checks++;
        if (n_press != 1 || press_at != 12)
            $display("FAIL abort_press: got %0d pulses at %0d, want 1 at 12", n_press, press_at);
        else n_pass++;
        for (int i = 0; i < 20; i++) step(RELEASED, 1'b0);
        n_checks++;
        if (level !== '0) $display("FAIL abort_final_level: got %b, want 000", level);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [N_BTN-1:0] pins = RELEASED;
        int dur[N_BTN];
        int n_bad = 0;
        for (int ch = 0; ch < N_BTN; ch++) dur[ch] = 1;
        for (int i = 0; i < 1500; i++) begin
            for (int ch = 0; ch < N_BTN; ch++) begin
                dur[ch]--;
                if (dur[ch] == 0) begin
                    pins[ch] = ~pins[ch];
                    dur[ch]  = int'($urandom_range(1, 28));
                end
            end
            step(pins, (i >= 700 && i < 703) ? 1'b1 : 1'b0);
            n_checks++;
            if (obs_v !== exp_v) begin
                n_bad++;
                $display("FAIL random_cycle %0d: got %b, want %b", i, obs_v, exp_v);
            end else n_pass++;
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_press();
        test_glitch();
        test_repeat();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
